// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle main-control sequencer.
package mc_pkg;

    // FSM encoding is visible on the debug state port, so the values are fixed.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMemory    = 3'd4,
        StFpuWait   = 3'd5,
        StWriteback = 3'd6,
        StHalt      = 3'd7
    } seq_state_t;

    // PC next-value select presented to the datapath mux.
    typedef logic [1:0] pc_src_t;

    localparam pc_src_t PC_SRC_SEQ      = 2'd0;
    localparam pc_src_t PC_SRC_BRANCH   = 2'd1;
    localparam pc_src_t PC_SRC_JUMP     = 2'd2;
    localparam pc_src_t PC_SRC_JUMP_REG = 2'd3;

    localparam int unsigned FPU_LATENCY_DEFAULT = 4;

    // FPU latency is limited to 1..255, so an 8-bit down-counter suffices.
    localparam int unsigned FPU_CNT_W = 8;

    // Cycles in IDLE and HALT are not counted as active execution time.
    function automatic logic is_active(seq_state_t st);
        return (st != StIdle) && (st != StHalt);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory request-acknowledge handshake seen by the sequencer.
interface multicycle_sequencer_if;

    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    // Sequencer side: raises requests, receives acknowledges.
    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    // Memory side: observes requests, returns acknowledges.
    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );

endinterface

// File: rtl/seq_perf_counters.sv
// Active-cycle and retired-instruction counters for the sequencer.
// Present only when SEQ_PERF_CNT_EN is defined; both counters wrap naturally.
`ifdef SEQ_PERF_CNT_EN
module seq_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;

    // Count active cycles and retire pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (active) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (retire) begin
                instr_q <= instr_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

endmodule
`endif

// File: rtl/multicycle_sequencer.sv
// Main-control FSM of the multi-cycle processor: steps each instruction through
// fetch, decode, execute, optional memory or FPU wait, and writeback, gating the
// decoder's write enables into single-cycle strobes.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined;
// otherwise cycle_cnt and instr_cnt are tied to zero.
module multicycle_sequencer
    import mc_pkg::*;
#(
    parameter int unsigned FPU_LATENCY = FPU_LATENCY_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,

    multicycle_sequencer_if.master mem,

    input  logic                   dec_reg_wr,
    input  logic                   dec_f_reg_wr,
    input  logic                   dec_branch,
    input  logic                   dec_jump,
    input  logic                   dec_jump_reg,
    input  logic                   dec_mem_wr,
    input  logic                   dec_mem_to_reg,
    input  logic                   dec_fpu_op,
    input  logic                   dec_halt,
    input  logic                   branch_cond,

    output logic                   ir_wr,
    output logic                   pc_wr,
    output pc_src_t                pc_src,
    output logic                   rf_wr,
    output logic                   frf_wr,
    output logic                   retire,
    output logic                   halted,
    output logic [2:0]             state,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instr_cnt
);

    localparam logic [FPU_CNT_W-1:0] FpuLatency = FPU_CNT_W'(FPU_LATENCY);

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [FPU_CNT_W-1:0] fpu_cnt_q;
    logic                 imem_req_q;
    logic                 dmem_req_q;
    logic                 dmem_we_q;
    logic                 halted_q;

    // Next state plus the Mealy strobes that depend on the current cycle's inputs.
    always_comb begin
        state_d = state_q;
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        pc_src  = PC_SRC_SEQ;
        rf_wr   = 1'b0;
        frf_wr  = 1'b0;
        retire  = 1'b0;

        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end

            StFetch: begin
                if (mem.imem_ack) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    pc_src  = PC_SRC_SEQ;
                    state_d = StDecode;
                end
            end

            StDecode: begin
                state_d = dec_halt ? StHalt : StExecute;
            end

            StExecute: begin
                if (dec_fpu_op) begin
                    state_d = StFpuWait;
                end else if (dec_jump) begin
                    pc_wr  = 1'b1;
                    pc_src = dec_jump_reg ? PC_SRC_JUMP_REG : PC_SRC_JUMP;
                    // Linking jumps still need a writeback cycle for the return address.
                    if (dec_reg_wr) begin
                        state_d = StWriteback;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (dec_branch) begin
                    pc_wr  = branch_cond;
                    pc_src = PC_SRC_BRANCH;
                    retire = 1'b1;
                end else if (dec_mem_wr || dec_mem_to_reg) begin
                    state_d = StMemory;
                end else begin
                    state_d = StWriteback;
                end
            end

            StMemory: begin
                if (mem.dmem_ack) begin
                    if (dec_mem_wr) begin
                        retire = 1'b1;
                    end else begin
                        state_d = StWriteback;
                    end
                end
            end

            StFpuWait: begin
                // Counter value 1 marks the final wait cycle.
                if (fpu_cnt_q == FPU_CNT_W'(1)) begin
                    state_d = StWriteback;
                end
            end

            StWriteback: begin
                rf_wr  = dec_reg_wr;
                frf_wr = dec_f_reg_wr;
                retire = 1'b1;
            end

            StHalt: begin
                state_d = StHalt;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // run is only looked at on the instruction boundary.
        if (retire) begin
            state_d = run ? StFetch : StIdle;
        end
    end

    // State register, FPU wait counter and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fpu_cnt_q  <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q == StExecute) && (state_d == StFpuWait)) begin
                fpu_cnt_q <= FpuLatency;
            end else if (state_q == StFpuWait) begin
                fpu_cnt_q <= fpu_cnt_q - FPU_CNT_W'(1);
            end

            // Moore outputs are decoded from the state being entered so they
            // line up with the state register without a combinational path.
            imem_req_q <= (state_d == StFetch);
            dmem_req_q <= (state_d == StMemory);
            dmem_we_q  <= (state_d == StMemory) && dec_mem_wr;
            halted_q   <= (state_d == StHalt);
        end
    end

    assign mem.imem_req = imem_req_q;
    assign mem.dmem_req = dmem_req_q;
    assign mem.dmem_we  = dmem_we_q;
    assign halted       = halted_q;
    assign state        = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic active;

    assign active = is_active(state_q);

    seq_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (active),
        .retire    (retire),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a responder answers memory
// requests after a programmable delay, each instruction pushes its expected
// trace to a scoreboard, and a monitor compares on every retire pulse.
module tb_multicycle_sequencer;
    import mc_pkg::*;

    localparam int unsigned FpuLat = 4;
    localparam int unsigned CntW   = 32;

    typedef enum int {KAlu, KLoad, KStore, KBranch, KJ, KJal, KJalr, KFpu} kind_e;

    typedef struct {
        logic [63:0] trace;
        int          cycles;
        int          ir_wr_n;
        int          pc_wr_n;
        logic        exec_pc_wr;
        logic [1:0]  exec_pc_src;
        int          rf_wr_n;
        int          frf_wr_n;
        int          dmem_n;
        logic        dmem_we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic dec_reg_wr = 1'b0, dec_f_reg_wr = 1'b0, dec_branch = 1'b0, dec_jump = 1'b0;
    logic dec_jump_reg = 1'b0, dec_mem_wr = 1'b0, dec_mem_to_reg = 1'b0;
    logic dec_fpu_op = 1'b0, dec_halt = 1'b0, branch_cond = 1'b0;

    logic            ir_wr, pc_wr, rf_wr, frf_wr, retire, halted;
    pc_src_t         pc_src;
    logic [2:0]      state;
    logic [CntW-1:0] cycle_cnt, instr_cnt;

    multicycle_sequencer_if mif ();

    multicycle_sequencer #(
        .FPU_LATENCY (FpuLat),
        .CNT_W       (CntW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .mem            (mif),
        .dec_reg_wr     (dec_reg_wr),
        .dec_f_reg_wr   (dec_f_reg_wr),
        .dec_branch     (dec_branch),
        .dec_jump       (dec_jump),
        .dec_jump_reg   (dec_jump_reg),
        .dec_mem_wr     (dec_mem_wr),
        .dec_mem_to_reg (dec_mem_to_reg),
        .dec_fpu_op     (dec_fpu_op),
        .dec_halt       (dec_halt),
        .branch_cond    (branch_cond),
        .ir_wr          (ir_wr),
        .pc_wr          (pc_wr),
        .pc_src         (pc_src),
        .rf_wr          (rf_wr),
        .frf_wr         (frf_wr),
        .retire         (retire),
        .halted         (halted),
        .state          (state),
        .cycle_cnt      (cycle_cnt),
        .instr_cnt      (instr_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    int   done_cnt = 0;
    int   exp_cycles = 0;
    int   exp_instr = 0;
    int   dmem_delay = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: ack after dmem_delay waiting cycles; fetches are zero-wait.
    initial begin
        int dwait;
        dwait = 0;
        mif.imem_ack = 1'b0;
        mif.dmem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mif.imem_ack = mif.imem_req;
            if (mif.dmem_req) begin
                if (dwait >= dmem_delay) begin
                    mif.dmem_ack = 1'b1;
                    dwait = 0;
                end else begin
                    mif.dmem_ack = 1'b0;
                    dwait++;
                end
            end else begin
                mif.dmem_ack = 1'b0;
                dwait = 0;
            end
        end
    end

    // Monitor: gather one instruction's observed behaviour and score it on retire.
    initial begin
        logic        in_instr;
        logic [63:0] m_trace;
        int          m_cyc, m_ir, m_pc, m_rf, m_frf, m_dm;
        logic        m_epw, m_we;
        logic [1:0]  m_eps;
        exp_t        e;
        in_instr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_instr = 1'b0;
            end else begin
                if (!in_instr && state == 3'd1) begin
                    in_instr = 1'b1;
                    m_trace = '0;
                    m_cyc = 0; m_ir = 0; m_pc = 0; m_rf = 0; m_frf = 0; m_dm = 0;
                    m_epw = 1'b0; m_eps = 2'd0; m_we = 1'b0;
                end
                if (in_instr && state == 3'd7) begin
                    in_instr = 1'b0;
                end else if (in_instr) begin
                    m_cyc++;
                    if (m_cyc <= 16) m_trace = {m_trace[59:0], 1'b0, state};
                    if (ir_wr) m_ir++;
                    if (pc_wr) m_pc++;
                    if (state == 3'd3) begin
                        m_epw = pc_wr;
                        m_eps = pc_src;
                    end
                    if (rf_wr) m_rf++;
                    if (frf_wr) m_frf++;
                    if (mif.dmem_req) begin
                        m_dm++;
                        if (mif.dmem_we) m_we = 1'b1;
                    end
                    if (retire) begin
                        if (sb_q.size() == 0) begin
                            check_eq("sb_unexpected_retire", 64'd1, 64'd0);
                        end else begin
                            e = sb_q.pop_front();
                            check_eq($sformatf("i%0d_trace", done_cnt), m_trace, e.trace);
                            check_eq($sformatf("i%0d_cycles", done_cnt), 64'(m_cyc), 64'(e.cycles));
                            check_eq($sformatf("i%0d_ir_wr", done_cnt), 64'(m_ir), 64'(e.ir_wr_n));
                            check_eq($sformatf("i%0d_pc_wr", done_cnt), 64'(m_pc), 64'(e.pc_wr_n));
                            check_eq($sformatf("i%0d_ex_pc_wr", done_cnt), 64'(m_epw),
                                     64'(e.exec_pc_wr));
                            check_eq($sformatf("i%0d_ex_pc_src", done_cnt), 64'(m_eps),
                                     64'(e.exec_pc_src));
                            check_eq($sformatf("i%0d_rf_wr", done_cnt), 64'(m_rf), 64'(e.rf_wr_n));
                            check_eq($sformatf("i%0d_frf_wr", done_cnt), 64'(m_frf),
                                     64'(e.frf_wr_n));
                            check_eq($sformatf("i%0d_dmem_req", done_cnt), 64'(m_dm),
                                     64'(e.dmem_n));
                            check_eq($sformatf("i%0d_dmem_we", done_cnt), 64'(m_we),
                                     64'(e.dmem_we));
                        end
                        in_instr = 1'b0;
                        done_cnt++;
                    end
                end
            end
        end
    end

    task automatic set_dec(input kind_e k);
        dec_reg_wr = 1'b0; dec_f_reg_wr = 1'b0; dec_branch = 1'b0; dec_jump = 1'b0;
        dec_jump_reg = 1'b0; dec_mem_wr = 1'b0; dec_mem_to_reg = 1'b0;
        dec_fpu_op = 1'b0; dec_halt = 1'b0;
        case (k)
            KAlu:    dec_reg_wr = 1'b1;
            KLoad:   begin dec_reg_wr = 1'b1; dec_mem_to_reg = 1'b1; end
            KStore:  dec_mem_wr = 1'b1;
            KBranch: dec_branch = 1'b1;
            KJ:      dec_jump = 1'b1;
            KJal:    begin dec_jump = 1'b1; dec_reg_wr = 1'b1; end
            KJalr:   begin dec_jump = 1'b1; dec_jump_reg = 1'b1; dec_reg_wr = 1'b1; end
            KFpu:    begin dec_fpu_op = 1'b1; dec_f_reg_wr = 1'b1; end
            default: ;
        endcase
    endtask

    // Reference model: expected state walk and strobe counts for one instruction.
    task automatic push_expected(input kind_e k, input logic bc, input int dly);
        exp_t e;
        int   st[$];
        st = {1, 2, 3};
        case (k)
            KAlu:        st.push_back(6);
            KLoad:       begin repeat (dly + 1) st.push_back(4); st.push_back(6); end
            KStore:      repeat (dly + 1) st.push_back(4);
            KFpu:        begin repeat (FpuLat) st.push_back(5); st.push_back(6); end
            KJal, KJalr: st.push_back(6);
            default:     ;
        endcase
        e.trace = '0;
        foreach (st[i]) if (i < 16) e.trace = {e.trace[59:0], 4'(st[i])};
        e.cycles      = st.size();
        e.ir_wr_n     = 1;
        e.exec_pc_wr  = (k == KJ || k == KJal || k == KJalr || (k == KBranch && bc));
        e.pc_wr_n     = 1 + int'(e.exec_pc_wr);
        e.exec_pc_src = (k == KJ || k == KJal) ? 2'd2 : (k == KJalr) ? 2'd3 :
                        (k == KBranch) ? 2'd1 : 2'd0;
        e.rf_wr_n     = (k == KAlu || k == KLoad || k == KJal || k == KJalr) ? 1 : 0;
        e.frf_wr_n    = (k == KFpu) ? 1 : 0;
        e.dmem_n      = (k == KLoad || k == KStore) ? dly + 1 : 0;
        e.dmem_we     = (k == KStore);
        sb_q.push_back(e);
        exp_cycles += e.cycles;
        exp_instr++;
    endtask

    task automatic check_counters(input string tag);
`ifdef SEQ_PERF_CNT_EN
        check_eq({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'(exp_cycles));
        check_eq({tag, "_instr_cnt"}, 64'(instr_cnt), 64'(exp_instr));
`else
        check_eq({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
        check_eq({tag, "_instr_cnt"}, 64'(instr_cnt), 64'd0);
`endif
    endtask

    // Drive one instruction; must be called before its DECODE cycle.
    task automatic run_instr(input kind_e k, input logic bc, input int dly, input logic drop);
        int   target;
        logic ok;
        set_dec(k);
        branch_cond = bc;
        dmem_delay  = dly;
        push_expected(k, bc, dly);
        target = done_cnt + 1;
        if (drop) begin
            @(negedge clk);
            @(negedge clk);
            run = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("retire_seen", 64'(ok), 64'd1);
        @(posedge clk);
        #2;
        check_counters("post_retire");
        if (drop) begin
            check_eq("idle_after_drop", 64'(state), 64'd0);
            repeat (3) @(negedge clk);
            check_eq("idle_stays", 64'(state), 64'd0);
            run = 1'b1;
        end
    endtask

    initial begin
        logic ok;
        // Reset state.
        #12;
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_imem_req", 64'(mif.imem_req), 64'd0);
        check_eq("rst_dmem_req", 64'(mif.dmem_req), 64'd0);
        check_eq("rst_halted", 64'(halted), 64'd0);
        check_eq("rst_retire", 64'(retire), 64'd0);
        check_counters("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_no_run", 64'(state), 64'd0);
        run = 1'b1;

        run_instr(KAlu,    1'b0, 0, 1'b0);
        run_instr(KLoad,   1'b0, 3, 1'b0);
        run_instr(KStore,  1'b0, 0, 1'b0);
        run_instr(KBranch, 1'b1, 0, 1'b0);
        run_instr(KBranch, 1'b0, 0, 1'b0);
        run_instr(KFpu,    1'b0, 0, 1'b0);
        run_instr(KJ,      1'b0, 0, 1'b0);
        run_instr(KJal,    1'b0, 0, 1'b0);
        run_instr(KJalr,   1'b0, 0, 1'b0);
        run_instr(KStore,  1'b0, 2, 1'b0);
        run_instr(KAlu,    1'b0, 0, 1'b1);

        // Halt: sticky, run ignored.
        set_dec(KAlu);
        dec_reg_wr = 1'b0;
        dec_halt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            if (state == 3'd7) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("halt_reached", 64'(ok), 64'd1);
        exp_cycles += 2;
        for (int i = 0; i < 20; i++) begin
            run = ~run;
            @(negedge clk);
            #2;
            check_eq("halt_sticky", 64'(halted), 64'd1);
            check_eq("halt_state", 64'(state), 64'd7);
        end
        check_counters("halt");

        // Reset clears halt.
        rst_n = 1'b0;
        dec_halt = 1'b0;
        #1;
        check_eq("halt_rst_halted", 64'(halted), 64'd0);
        check_eq("halt_rst_state", 64'(state), 64'd0);
        exp_cycles = 0;
        exp_instr = 0;
        repeat (2) @(negedge clk);
        run = 1'b1;
        rst_n = 1'b1;

        // Reset in the middle of a stalled data access.
        set_dec(KLoad);
        dmem_delay = 50;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (state == 3'd4) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("mem_reached", 64'(ok), 64'd1);
        check_eq("mem_req_high", 64'(mif.dmem_req), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_dmem_req", 64'(mif.dmem_req), 64'd0);
        check_eq("async_rst_state", 64'(state), 64'd0);
        check_eq("async_rst_imem_req", 64'(mif.imem_req), 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_instr(KAlu, 1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
